// File: rtl/bht_counter_table.sv
// Direct-mapped table of 2-bit saturating branch counters, trained by resolved branches
// and read combinationally by PC generation. A clearing sweep invalidates it after reset/flush.
module bht_counter_table #(
  parameter int unsigned VLEN        = 39,
  parameter int unsigned NR_ENTRIES  = 1024,
  parameter int unsigned OFFSET_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  input  logic            lookup_valid_i,
  output logic            bht_valid_o,
  output logic            bht_taken_o,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_is_branch_i,
  input  logic            upd_taken_i,
  output logic            busy_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  typedef struct packed {
    logic valid;
    idx_t idx;
    logic taken;
  } upd_t;

  state_e     state_q, state_d;
  idx_t       clr_idx_q, clr_idx_d;
  upd_t       upd_q, upd_d;

  logic       valid_q [NR_ENTRIES];
  logic [1:0] cnt_q   [NR_ENTRIES];

  idx_t       lookup_idx, upd_idx;
  logic       clr_we, upd_we;
  logic [1:0] upd_new_cnt;
  logic       lk_valid;
  logic [1:0] lk_cnt;

  assign lookup_idx = lookup_pc_i[OFFSET_BITS+IDX_W-1:OFFSET_BITS];
  assign upd_idx    = upd_pc_i[OFFSET_BITS+IDX_W-1:OFFSET_BITS];

  // The table is untagged, so the remaining PC bits carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[VLEN-1:OFFSET_BITS+IDX_W], lookup_pc_i[OFFSET_BITS-1:0],
                            upd_pc_i[VLEN-1:OFFSET_BITS+IDX_W], upd_pc_i[OFFSET_BITS-1:0]};

  function automatic logic [1:0] next_cnt(input logic ent_valid, input logic [1:0] cnt,
                                          input logic taken);
    logic [1:0] res;
    if (!ent_valid)     res = taken ? 2'd2 : 2'd1;
    else if (taken)     res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    else                res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    return res;
  endfunction

  assign upd_new_cnt = next_cnt(valid_q[upd_q.idx], cnt_q[upd_q.idx], upd_q.taken);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;

    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx_q == idx_t'(NR_ENTRIES - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + idx_t'(1);
        end
      end
      IDLE: ;
      default: state_d = CLEAR;
    endcase

    if (flush_bp_i) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end

    // A flush kills both a new capture and any write still pending from last cycle.
    upd_d.valid = upd_valid_i & upd_is_branch_i & ~debug_mode_i & (state_q == IDLE) & ~flush_bp_i;
    upd_d.idx   = upd_idx;
    upd_d.taken = upd_taken_i;
    upd_we      = upd_q.valid & ~flush_bp_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      upd_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      upd_q     <= upd_d;
    end
  end

  // NOTE: the storage array has no reset; the clearing sweep is what makes its contents meaningful.
  always_ff @(posedge clk_i) begin
    if (clr_we) valid_q[clr_idx_q] <= 1'b0;
    if (upd_we) begin
      valid_q[upd_q.idx] <= 1'b1;
      cnt_q[upd_q.idx]   <= upd_new_cnt;
    end
  end

  always_comb begin
    lk_valid = valid_q[lookup_idx];
    lk_cnt   = cnt_q[lookup_idx];
    if (upd_q.valid && (upd_q.idx == lookup_idx)) begin
      lk_valid = 1'b1;
      lk_cnt   = upd_new_cnt;
    end
  end

  assign busy_o      = (state_q == CLEAR);
  assign bht_valid_o = lookup_valid_i & (state_q == IDLE) & lk_valid;
  assign bht_taken_o = bht_valid_o & lk_cnt[1];

endmodule

// File: tb/tb_bht_counter_table.sv
// Scoreboard bench for bht_counter_table: directed plan scenarios, then random traffic,
// all checked against an array-based model of the counter table.
module tb_bht_counter_table;

  localparam int unsigned VLEN        = 39;
  localparam int unsigned NR_ENTRIES  = 4;
  localparam int unsigned OFFSET_BITS = 1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_bp_i = 1'b0;
  logic            debug_mode_i = 1'b0;
  logic [VLEN-1:0] lookup_pc_i = '0;
  logic            lookup_valid_i = 1'b0;
  logic            bht_valid_o;
  logic            bht_taken_o;
  logic            upd_valid_i = 1'b0;
  logic [VLEN-1:0] upd_pc_i = '0;
  logic            upd_is_branch_i = 1'b0;
  logic            upd_taken_i = 1'b0;
  logic            busy_o;

  bht_counter_table #(
    .VLEN(VLEN), .NR_ENTRIES(NR_ENTRIES), .OFFSET_BITS(OFFSET_BITS)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
    .lookup_pc_i(lookup_pc_i), .lookup_valid_i(lookup_valid_i),
    .bht_valid_o(bht_valid_o), .bht_taken_o(bht_taken_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_branch_i(upd_is_branch_i),
    .upd_taken_i(upd_taken_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit busy;
    bit v;
    bit t;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: per-entry valid flag and integer counter, one pending update,
  // and the number of sweep cycles still to run.
  bit m_valid [NR_ENTRIES];
  int m_cnt   [NR_ENTRIES];
  bit p_v;
  int p_idx;
  bit p_t;
  int busy_left;

  function automatic int pc_idx(input logic [VLEN-1:0] pc);
    return int'((pc >> OFFSET_BITS) % NR_ENTRIES);
  endfunction

  function automatic int trained(input bit v, input int c, input bit t);
    if (!v) return t ? 2 : 1;
    if (t)  return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    p_v       = 1'b0;
    busy_left = NR_ENTRIES;
  endtask

  task automatic model_edge(input bit uv, input logic [VLEN-1:0] upc, input bit ub,
                            input bit ut, input bit dbg, input bit fl);
    bit was_busy = (busy_left > 0);
    if (p_v && !fl) begin
      m_cnt[p_idx]   = trained(m_valid[p_idx], m_cnt[p_idx], p_t);
      m_valid[p_idx] = 1'b1;
    end
    if (was_busy) begin
      m_valid[NR_ENTRIES - busy_left] = 1'b0;
      busy_left--;
    end
    if (fl) busy_left = NR_ENTRIES;
    p_v   = uv && ub && !dbg && !was_busy && !fl;
    p_idx = pc_idx(upc);
    p_t   = ut;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle (called at posedge+1), queue its expected outputs, then advance the model.
  task automatic step(input bit lv, input logic [VLEN-1:0] lpc, input bit uv,
                      input logic [VLEN-1:0] upc, input bit ub, input bit ut,
                      input bit dbg, input bit fl);
    exp_t e;
    int   i;
    bit   ev;
    int   ec;
    lookup_valid_i  = lv;
    lookup_pc_i     = lpc;
    upd_valid_i     = uv;
    upd_pc_i        = upc;
    upd_is_branch_i = ub;
    upd_taken_i     = ut;
    debug_mode_i    = dbg;
    flush_bp_i      = fl;
    e.busy = (busy_left > 0);
    e.v    = 1'b0;
    e.t    = 1'b0;
    if (lv && !e.busy) begin
      i  = pc_idx(lpc);
      ev = m_valid[i];
      ec = m_cnt[i];
      if (p_v && p_idx == i) begin
        ec = trained(ev, ec, p_t);
        ev = 1'b1;
      end
      e.v = ev;
      e.t = ev && (ec >= 2);
    end
    sb_q.push_back(e);
    @(posedge clk_i);
    model_edge(uv, upc, ub, ut, dbg, fl);
    #1;
  endtask

  task automatic lookup(input logic [VLEN-1:0] pc);
    step(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd_look(input logic [VLEN-1:0] upc, input bit ut, input logic [VLEN-1:0] lpc);
    step(1'b1, lpc, 1'b1, upc, 1'b1, ut, 1'b0, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) lookup(39'h1000);
  endtask

  // Monitor: busy_o every cycle, lookup outputs too (they must read 0 when no prediction is due).
  always @(negedge clk_i) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("busy_o", busy_o, e.busy);
      check("bht_valid_o", bht_valid_o, e.v);
      check("bht_taken_o", bht_taken_o, e.t);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0", sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NR_ENTRIES; k++) begin
      m_valid[k] = 1'b0;
      m_cnt[k]   = 0;
    end
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    model_reset();

    // Sweep after reset: four busy cycles, then an invalid lookup.
    idle_cycles(NR_ENTRIES + 1);

    // Train taken to saturation with forwarding, then walk back down.
    upd_look(39'h1000, 1'b1, 39'h1000);
    upd_look(39'h1000, 1'b1, 39'h1000);
    upd_look(39'h1000, 1'b1, 39'h1000);
    lookup(39'h1000);
    upd_look(39'h1000, 1'b0, 39'h1000);
    upd_look(39'h1000, 1'b0, 39'h1000);
    upd_look(39'h1000, 1'b0, 39'h1000);
    lookup(39'h1000);
    lookup(39'h1000);

    // Aliasing: 0x1008 and 0x1000 share index 0.
    upd_look(39'h1008, 1'b1, 39'h1000);
    upd_look(39'h1008, 1'b1, 39'h1000);
    lookup(39'h1000);

    // Flush, then non-branch and debug-mode updates must not train.
    step(1'b1, 39'h1000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(NR_ENTRIES);
    step(1'b1, 39'h1002, 1'b1, 39'h1002, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 39'h1002, 1'b1, 39'h1004, 1'b1, 1'b1, 1'b1, 1'b0);
    lookup(39'h1002);
    lookup(39'h1004);

    // Captured update killed by a flush in the following cycle.
    step(1'b1, 39'h1006, 1'b1, 39'h1006, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 39'h1006, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(NR_ENTRIES);
    lookup(39'h1006);

    // Flush restarted mid-sweep, then reset asserted mid-sweep with an update offered.
    upd_look(39'h1002, 1'b1, 39'h1002);
    step(1'b1, 39'h1002, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);
    step(1'b1, 39'h1002, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(1);
    begin
      exp_t e;
      rst_ni = 1'b0;
      lookup_valid_i = 1'b1;
      upd_valid_i = 1'b1;
      upd_is_branch_i = 1'b1;
      e.busy = 1'b1; e.v = 1'b0; e.t = 1'b0;
      sb_q.push_back(e);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      upd_valid_i = 1'b0;
      model_reset();
    end
    idle_cycles(NR_ENTRIES + 1);

    // Random traffic over a handful of aliasing PCs.
    for (int n = 0; n < 400; n++) begin
      logic [VLEN-1:0] lpc, upc;
      lpc = 39'h1000 + 39'($urandom_range(0, 7) * 2);
      upc = 39'h1000 + 39'($urandom_range(0, 7) * 2);
      step(1'($urandom_range(0, 3) != 0), lpc, 1'($urandom_range(0, 2) != 0), upc,
           1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));
    end

    lookup_valid_i = 1'b0;
    upd_valid_i    = 1'b0;
    flush_bp_i     = 1'b0;
    repeat (2) @(negedge clk_i);
    check("scoreboard_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bht_counter_table.md
# bht_counter_table

Branch history table on the frontend side of branch resolution. Consumes the resolved-branch stream produced by the execute-stage branch unit (pc, taken, cf type) and trains a direct-mapped table of 2-bit saturating counters. In return it serves taken/not-taken predictions to PC generation for the current fetch PC. Storage is modelled as a non-reset array. Validity is established by a clearing sweep after reset and after every predictor flush.

## Interface
Parameters:
- VLEN, 39, virtual address width.
- NR_ENTRIES, 1024, number of table entries; power of two, at least 4.
- OFFSET_BITS, 1, low PC bits dropped before indexing (1 for RVC, 2 otherwise).

Ports (IDX_W = log2(NR_ENTRIES)):
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_bp_i  in  1  predictor flush request; starts a clearing sweep.
- debug_mode_i  in  1  core is in debug mode; all training is suppressed.
- lookup_pc_i  in  VLEN  fetch PC to predict.
- lookup_valid_i  in  1  lookup request.
- bht_valid_o  out  1  prediction valid.
- bht_taken_o  out  1  predicted taken.
- upd_valid_i  in  1  resolved branch valid.
- upd_pc_i  in  VLEN  PC of the resolved instruction.
- upd_is_branch_i  in  1  resolved cf type equals Branch; only these updates train the table.
- upd_taken_i  in  1  actual branch outcome.
- busy_o  out  1  clearing sweep in progress.

## Operation
- Index: idx = pc[OFFSET_BITS+IDX_W-1 : OFFSET_BITS]. The table is direct-mapped with no tag.
- Each entry holds a valid bit and a 2-bit counter: 0 strongly not-taken, 1 weakly not-taken, 2 weakly taken, 3 strongly taken.
- State machine:
  - CLEAR: clr_idx counts from 0 to NR_ENTRIES-1, writing valid=0 to entry clr_idx each cycle. After entry NR_ENTRIES-1 is written, the FSM moves to IDLE. busy_o is 1 throughout CLEAR.
  - IDLE: normal operation. flush_bp_i=1 moves the FSM to CLEAR with clr_idx=0.
  - flush_bp_i asserted while already in CLEAR restarts the sweep at clr_idx=0.
- Update capture, one register stage (upd_q):
  - Captured when upd_valid_i & upd_is_branch_i & !debug_mode_i & state==IDLE & !flush_bp_i.
  - All other updates are dropped silently.
- Update apply, the cycle after capture:
  - Read entry[upd_q.idx] and compute the new value.
  - Invalid entry: new = {valid=1, cnt = taken ? 2 : 1}.
  - Valid entry: taken gives cnt = min(cnt+1, 3); not-taken gives cnt = max(cnt-1, 0).
  - Write at the end of the cycle.
  - Back-to-back updates to the same index therefore chain correctly: each read sees the previous write.
- Pending update versus flush: if flush_bp_i is high while upd_q is valid, the pending write is discarded and upd_q is cleared.
- Lookup, combinational:
  - bht_valid_o = lookup_valid_i & state==IDLE & entry.valid.
  - bht_taken_o = bht_valid_o & entry.cnt[1].
  - If upd_q is valid with the same idx, the lookup returns the computed new value (forwarding).
  - Outputs are 0 whenever lookup_valid_i=0 or busy_o=1.

## Timing
- On reset: state CLEAR, clr_idx=0, upd_q invalid, busy_o=1, bht_valid_o=0, bht_taken_o=0.
- The first IDLE cycle is NR_ENTRIES cycles after reset release.
- Flush asserted in cycle T: busy_o=1 from cycle T+1 through T+NR_ENTRIES.
- Update latency: accepted at the edge ending cycle T; visible to lookups in cycle T+1 via forwarding and from the array in T+2.
- Lookup latency is 0 cycles.
- Reset asserted mid-sweep or mid-update returns to the reset state immediately; no partial write completes.
- There are no stall or ready signals. The block accepts at most one update per cycle and never back-pressures.

## Test plan
- Reset, NR_ENTRIES=4: busy_o=1 for 4 cycles, then 0. A lookup at PC 0x1000 gives bht_valid_o=0.
- Update PC 0x1000 taken, then lookup 0x1000 in the next cycle: valid=1, taken=1 (forwarded cnt=2). Two more taken updates saturate at cnt=3.
- From cnt=3, apply three not-taken updates to 0x1000 on consecutive cycles: cnt goes 2, 1, 0. Taken flips to 0 after the second update.
- Aliasing, NR_ENTRIES=4, OFFSET_BITS=1: PCs 0x1000 and 0x1008 share idx 0. A taken update to 0x1008 gives taken=1 for a lookup at 0x1000.
- An update with upd_is_branch_i=0, or with debug_mode_i=1, leaves the entry invalid: bht_valid_o=0.
- Update captured with flush_bp_i asserted in the following cycle: the write is discarded. After the 4-cycle sweep, a lookup gives valid=0.
